uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin transmit scheduler that shares the single UART transmitter among `NREQ` byte requesters. It sits between the client logic and the transmitter inside the UART top level, and grants one requester at a time. It drives the transmitter's start strobe and data byte, then holds off further grants for a full frame plus a configurable idle gap. Busy timing is derived from `bps_clk_up` ticks counted from the baud generator, because the transmitter has no done/busy output.

## Interface
- `NREQ`, default 4: number of requesters; legal values 2, 4, 8.
- `FRAME_BITS`, default 10: bit periods per frame (start + 8 data + stop); legal range 1..15.
- `GAP_BITS`, default 1: idle bit periods inserted after each frame; legal range 0..15.
- `sys_clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bps_clk_up`  in  1  one-`sys_clk` pulse per bit period, from the baud generator.
- `req_valid`  in  NREQ  bit i = requester i has a byte pending.
- `req_data`  in  8*NREQ  requester i byte in bits [8i+7:8i].
- `req_ready`  out  NREQ  one-hot accept; a byte transfers on an edge where `req_valid[i] & req_ready[i]`.
- `tx_ready`  out  1  start strobe to the transmitter.
- `tx_data_o`  out  8  byte to the transmitter; stable from the grant until the next grant.
- `grant_id`  out  log2(NREQ)  index of the most recently granted requester.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse on the return to IDLE.

## Operation
- States: IDLE, START, FRAME, GAP. A 4-bit `bit_cnt` counts ticks.
- **IDLE**
  - The winner is the first set `req_valid` bit, searching from index `grant_id+1` upward and wrapping mod `NREQ`; `grant_id` itself is searched last.
  - `req_ready` is combinational: it is the winner's one-hot bit in IDLE and 0 in all other states.
  - At the handshake edge: `tx_data_o` <= winner's byte, `grant_id` <= winner index, go to START.
  - With no `req_valid` bits set, remain in IDLE.
- **START**
  - `tx_ready` = 1.
  - On a cycle with `bps_clk_up` = 1: `bit_cnt` <= 0, go to FRAME.
- **FRAME**
  - On each `bps_clk_up`: `bit_cnt++`.
  - On the tick where `bit_cnt == FRAME_BITS-1`:
    - if `GAP_BITS` > 0: `bit_cnt` <= 0, go to GAP;
    - if `GAP_BITS` = 0: go to IDLE.
- **GAP**
  - On each `bps_clk_up`: `bit_cnt++`.
  - On the tick where `bit_cnt == GAP_BITS-1`: go to IDLE.
- `frame_done` is registered: high for the one cycle after the transition into IDLE.
- Requesters must hold `req_valid` and `req_data` until accepted. Dropping `req_valid` before acceptance is legal; nothing transfers.
- Fairness: a continuously asserting requester waits at most `NREQ-1` frames.

## Timing
- Reset values: `tx_ready` 0, `tx_data_o` 8'h00, `grant_id` = NREQ-1 (requester 0 has first priority), `busy` 0, `frame_done` 0, state IDLE, `bit_cnt` 0.
- `req_ready` is 0 while `rst_n` = 0.
- Latency:
  - Grant edge to `tx_ready` high: 1 cycle.
  - `tx_ready` stays high through the cycle of the first `bps_clk_up` after the grant, inclusive, then drops.
- `busy` rises the cycle after the grant edge. It falls after `FRAME_BITS + GAP_BITS` ticks following the START-terminating tick.
- A `bps_clk_up` in the same cycle as the grant edge is ignored; START waits for a later tick.
- A tick in the first START cycle ends START immediately, so `tx_ready` is high for exactly 1 cycle.
- With `GAP_BITS` = 0, the next grant can occur in the first IDLE cycle (back-to-back frames).
- Reset asserted mid-operation: all outputs go to reset values asynchronously. The in-flight byte is abandoned and not retried, and the round-robin pointer returns to NREQ-1.

## Test plan
- **Single grant.** `NREQ`=4, `req_valid`=4'b0100, byte 0xA5 → `req_ready`=4'b0100 for 1 cycle, `tx_data_o`=0xA5, `grant_id`=2, `tx_ready` high until the next tick, `busy` high for 1+10+1 ticks, one `frame_done` pulse.
- **Full contention.** All four `req_valid` held high with bytes 0x10..0x13 → grant order 0,1,2,3,0, and `tx_data_o` sequence 0x10,0x11,0x12,0x13,0x10.
- **Pointer wrap.** After a grant to 2, with `req_valid`=4'b1010 → grant 3 next, then 1. `req_ready` is never asserted outside IDLE.
- **Reset mid-frame.** Assert `rst_n` low at tick 5 of FRAME → all outputs immediately at reset values. After release with `req_valid`=4'b1111, the first grant goes to 0.
- **Back-to-back, no gap.** `GAP_BITS`=0 with two pending requesters → the second grant lands in the first IDLE cycle after the 10th tick, and `tx_data_o` is unchanged throughout each frame.
- **Coincident tick.** `bps_clk_up` in the grant cycle → ignored; `tx_ready` stays high until the following tick. A tick in the first START cycle gives a 1-cycle `tx_ready`.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester-side valid/ready byte bus feeding the transmit scheduler.
interface uart_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  modport master (output req_valid, req_data, input req_ready);
  modport slave  (input req_valid, req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin grant of the single UART transmitter among NREQ byte requesters,
// holding off the next grant for a full frame plus an idle gap counted in baud ticks.
module uart_tx_sched #(
  parameter int  NREQ       = 4,
  parameter int  FRAME_BITS = 10,
  parameter int  GAP_BITS   = 1,
  localparam int IW         = $clog2(NREQ)
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic           bps_clk_up,
  uart_tx_sched_if.slave req,
  output logic           tx_ready,
  output logic [7:0]     tx_data_o,
  output logic [IW-1:0]  grant_id,
  output logic           busy,
  output logic           frame_done
);
  typedef enum logic [1:0] {IDLE, START, FRAME, GAP} state_e;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] gid_q, gid_d, win, idx;
  logic [7:0]    data_q, data_d;
  logic          found, fd_q, fr_last, gap_last;
  // NREQ is a power of two, so the IW-bit add wraps; k == NREQ lands back on gid_q, searched last
  always_comb begin
    win = gid_q;
    idx = gid_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = gid_q + IW'(k);
      if (!found && req.req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign fr_last  = cnt_q == 4'(FRAME_BITS - 1);
  assign gap_last = cnt_q == 4'(GAP_BITS - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gid_d = gid_q;
    data_d = data_q;
    req.req_ready = '0;
    case (state_q)
      IDLE: if (found && rst_n) begin
        req.req_ready = NREQ'(1) << win;
        gid_d = win;
        data_d = req.req_data[8*win +: 8];
        state_d = START;
      end
      START: if (bps_clk_up) begin
        cnt_d = '0;
        state_d = FRAME;
      end
      FRAME: if (bps_clk_up) begin
        cnt_d = fr_last ? 4'd0 : cnt_q + 4'd1;
        if (fr_last) state_d = (GAP_BITS > 0) ? GAP : IDLE;
      end
      GAP: if (bps_clk_up) begin
        cnt_d = cnt_q + 4'd1;
        if (gap_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gid_q <= IW'(NREQ - 1);
      data_q <= '0;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gid_q <= gid_d;
      data_q <= data_d;
      fd_q <= state_q != IDLE && state_d == IDLE;
    end
  assign tx_ready   = state_q == START;
  assign tx_data_o  = data_q;
  assign grant_id   = gid_q;
  assign busy       = state_q != IDLE;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: instance 0 has a 1-bit gap, instance 1 has no gap; a transaction-level
// model predicts every output each cycle, and directed vectors pin literal expectations.
module tb_uart_tx_sched;
  localparam int N = 4;
  localparam int F = 10;
  logic clk = 1'b0, rst_n = 1'b0, auto_en = 1'b0, man = 1'b0, tick;
  int tcnt = 0, total = 0, bad = 0, bt = 0, fdc = 0;
  logic [1:0][3:0]  v = '0, rdy;
  logic [1:0][31:0] d = '0;
  logic [1:0][7:0]  data_o;
  logic [1:0][1:0]  gid_o;
  logic [1:0]       txr, busy_o, fd;
  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= (tcnt + 1) % 4;
  assign tick = man | (auto_en && tcnt == 3);

  uart_tx_sched_if #(.NREQ(N)) ba ();
  uart_tx_sched_if #(.NREQ(N)) bb ();
  assign ba.req_valid = v[0];
  assign ba.req_data  = d[0];
  assign rdy[0]       = ba.req_ready;
  assign bb.req_valid = v[1];
  assign bb.req_data  = d[1];
  assign rdy[1]       = bb.req_ready;

  uart_tx_sched #(.NREQ(N), .FRAME_BITS(F), .GAP_BITS(1)) dut_a (
    .sys_clk(clk), .rst_n(rst_n), .bps_clk_up(tick), .req(ba), .tx_ready(txr[0]),
    .tx_data_o(data_o[0]), .grant_id(gid_o[0]), .busy(busy_o[0]), .frame_done(fd[0]));
  uart_tx_sched #(.NREQ(N), .FRAME_BITS(F), .GAP_BITS(0)) dut_b (
    .sys_clk(clk), .rst_n(rst_n), .bps_clk_up(tick), .req(bb), .tx_ready(txr[1]),
    .tx_data_o(data_o[1]), .grant_id(gid_o[1]), .busy(busy_o[1]), .frame_done(fd[1]));

  // model: a granted frame waits for one later tick to start, then lasts FRAME+GAP ticks
  bit   m_busy[2], m_st[2], m_fd[2];
  int   m_left[2], m_gid[2];
  logic [7:0] m_data[2];
  function automatic int pick(int g, logic [3:0] vv);
    for (int k = 1; k <= N; k++) if (vv[(g + k) % N]) return (g + k) % N;
    return -1;
  endfunction
  function automatic logic [3:0] exp_rdy(int i);
    int w = pick(m_gid[i], v[i]);
    return (!rst_n || m_busy[i] || w < 0) ? 4'b0 : 4'(1 << w);
  endfunction
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++) begin
      int w;
      w = pick(m_gid[i], v[i]);
      if (!rst_n) begin
        m_busy[i] = 0; m_st[i] = 0; m_fd[i] = 0; m_left[i] = 0; m_gid[i] = N - 1; m_data[i] = 8'h00;
      end else begin
        m_fd[i] = 0;
        if (!m_busy[i]) begin
          if (w >= 0) begin
            m_busy[i] = 1; m_st[i] = 0; m_gid[i] = w; m_data[i] = d[i][8*w +: 8];
          end
        end else if (!m_st[i]) begin
          if (tick) begin m_st[i] = 1; m_left[i] = F + (i == 0 ? 1 : 0); end
        end else if (tick) begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_busy[i] = 0; m_fd[i] = 1; end
        end
      end
    end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m_rdy%0d", i), 32'(rdy[i]), 32'(exp_rdy(i)));
      chk($sformatf("m_txr%0d", i), 32'(txr[i]), 32'(m_busy[i] && !m_st[i]));
      chk($sformatf("m_busy%0d", i), 32'(busy_o[i]), 32'(m_busy[i]));
      chk($sformatf("m_data%0d", i), 32'(data_o[i]), 32'(m_data[i]));
      chk($sformatf("m_gid%0d", i), 32'(gid_o[i]), 32'(m_gid[i]));
      chk($sformatf("m_fd%0d", i), 32'(fd[i]), 32'(m_fd[i]));
    end
  always @(negedge clk) begin
    if (busy_o[0] && tick) bt++;
    if (fd[0]) fdc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic take(int i, int e, logic [7:0] b, bit drop);
    int c = 0;
    do begin @(negedge clk); c++; end while (rdy[i] == 4'b0 && c < 300);
    chk("grant_rdy", 32'(rdy[i]), 32'(4'b1 << e));
    step();
    if (drop) v[i][e] = 1'b0;
    @(negedge clk);
    chk("grant_id", 32'(gid_o[i]), 32'(e));
    chk("grant_data", 32'(data_o[i]), 32'(b));
    chk("grant_busy", 32'(busy_o[i]), 1);
  endtask
  task automatic wait_idle(int i);
    int c = 0;
    do begin @(negedge clk); c++; end while ((busy_o[i] || fd[i]) && c < 400);
    chk("idle_reached", 32'(c < 400), 1);
  endtask
  task automatic pulse_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int b0, f0, n;
    repeat (3) step();
    chk("rst_gid", 32'(gid_o[0]), 3);
    chk("rst_data", 32'(data_o[0]), 0);
    chk("rst_busy", 32'(busy_o[0]), 0);
    chk("rst_txr", 32'(txr[0]), 0);
    rst_n = 1'b1;
    auto_en = 1'b1;
    // full contention after reset: 0,1,2,3,0
    v[0] = 4'b1111;
    d[0] = 32'h13121110;
    take(0, 0, 8'h10, 0);
    take(0, 1, 8'h11, 0);
    take(0, 2, 8'h12, 0);
    take(0, 3, 8'h13, 0);
    take(0, 0, 8'h10, 0);
    step();
    v[0] = 4'b0;
    wait_idle(0);
    // single grant to requester 2
    step();
    b0 = bt;
    f0 = fdc;
    v[0] = 4'b0100;
    d[0] = 32'h00A50000;
    take(0, 2, 8'hA5, 1);
    wait_idle(0);
    chk("single_ticks", 32'(bt - b0), 12);
    chk("single_fd", 32'(fdc - f0), 1);
    // pointer wrap from 2 with 4'b1010
    step();
    v[0] = 4'b1010;
    d[0] = 32'hD4C3B2A1;
    take(0, 3, 8'hD4, 1);
    take(0, 1, 8'hB2, 1);
    wait_idle(0);
    // reset at tick 5 of FRAME
    step();
    v[0] = 4'b0001;
    d[0] = 32'h00000055;
    take(0, 0, 8'h55, 1);
    n = 0;
    while (txr[0] && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (n < 5) begin @(negedge clk); if (tick) n++; end
    @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(busy_o[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_txr", 32'(txr[0]), 0);
    chk("arst_data", 32'(data_o[0]), 0);
    chk("arst_gid", 32'(gid_o[0]), 3);
    chk("arst_busy", 32'(busy_o[0]), 0);
    chk("arst_fd", 32'(fd[0]), 0);
    v[0] = 4'b1111;
    d[0] = 32'h44332211;
    #1;
    chk("arst_rdy", 32'(rdy[0]), 0);
    step();
    rst_n = 1'b1;
    take(0, 0, 8'h11, 0);
    step();
    v[0] = 4'b0;
    wait_idle(0);
    // no-gap instance: second grant in the first IDLE cycle
    step();
    v[1] = 4'b0011;
    d[1] = 32'h0000BBAA;
    take(1, 0, 8'hAA, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (busy_o[1] && n < 300);
    chk("b2b_rdy", 32'(rdy[1]), 32'(4'b0010));
    chk("b2b_fd", 32'(fd[1]), 1);
    step();
    v[1][1] = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 32'(busy_o[1]), 1);
    chk("b2b_gid", 32'(gid_o[1]), 1);
    chk("b2b_data", 32'(data_o[1]), 32'h BB);
    wait_idle(1);
    // tick coincident with the grant edge is ignored
    step();
    auto_en = 1'b0;
    step();
    v[0] = 4'b0100;
    d[0] = 32'h003C0000;
    man = 1'b1;
    step();
    v[0] = 4'b0;
    man = 1'b0;
    @(negedge clk);
    chk("coinc_txr", 32'(txr[0]), 1);
    chk("coinc_data", 32'(data_o[0]), 32'h3C);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("coinc_hold", 32'(txr[0]), 1);
    end
    step();
    man = 1'b1;
    @(negedge clk);
    chk("coinc_incl", 32'(txr[0]), 1);
    step();
    man = 1'b0;
    @(negedge clk);
    chk("coinc_drop", 32'(txr[0]), 0);
    chk("coinc_busy", 32'(busy_o[0]), 1);
    auto_en = 1'b1;
    wait_idle(0);
    // tick in the first START cycle: one-cycle tx_ready
    step();
    auto_en = 1'b0;
    v[0] = 4'b0100;
    d[0] = 32'h00C30000;
    step();
    v[0] = 4'b0;
    man = 1'b1;
    @(negedge clk);
    chk("start1_txr", 32'(txr[0]), 1);
    step();
    man = 1'b0;
    @(negedge clk);
    chk("start1_drop", 32'(txr[0]), 0);
    auto_en = 1'b1;
    wait_idle(0);
    pulse_reset();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
